pipeline_sequencer: RTL and testbench
=====================================

Name: pipeline_sequencer

Overview:
- Front-end controller for the 2-stage fetch/decode pipe feeding the branching unit.
- Owns PC_IF, PC_DEC and valid_DEC.
- Sequences redirect on taken branch, load-use stalls, instruction-memory wait and data-memory freeze.
- Drives hold/flush to the IF/DEC pipeline registers and keeps stall statistics for bring-up.

Parameters:
- RESET_PC, 32'h0000_0000, PC_IF value after reset.
- BRANCH_PENALTY, 1, bubbles inserted into DEC after a taken branch (1..3).
- CNT_W, 16, width of each performance counter.

Ports:
- Clock  in  1  system clock, rising edge.
- nReset  in  1  asynchronous active-low reset.
- imem_ready  in  1  instruction word for PC_IF is valid this cycle.
- dmem_ready  in  1  data-memory access in DEC completes this cycle.
- mem_op_DEC  in  1  DEC instruction is a load/store.
- is_load_DEC  in  1  DEC instruction is a load.
- rd_DEC  in  5  DEC destination register.
- rs1_IF, rs2_IF  in  5 each  IF source registers.
- uses_rs1_IF, uses_rs2_IF  in  1 each  IF instruction reads rs1/rs2.
- branch_taken  in  1  branching unit resolves a taken branch/jump for DEC.
- branch_target  in  32  redirect address, word-aligned.
- PC_IF  out  32  fetch PC, registered.
- PC_DEC  out  32  PC of the DEC instruction, registered.
- valid_DEC  out  1  DEC holds a real instruction, registered.
- hold_IF  out  1  IF pipeline register must not load, combinational.
- hold_DEC  out  1  DEC pipeline register must not load, combinational.
- flush_DEC  out  1  DEC loads a bubble next edge, combinational.
- stall_cnt  out  CNT_W  cycles with hold_IF=1, saturating.
- flush_cnt  out  CNT_W  taken redirects, saturating.

Behaviour:
- Reset (async, any state): PC_IF=RESET_PC, PC_DEC=0, valid_DEC=0, state=RUN, counters=0.
- States: RUN, REDIRECT, LOAD_STALL, DMEM_WAIT. Per-cycle events are evaluated in strict priority; the first match wins.
- 1) DMEM_WAIT condition (valid_DEC & mem_op_DEC & !dmem_ready):
  - Freeze all: hold_IF=1, hold_DEC=1, flush_DEC=0.
  - PC_IF, PC_DEC and valid_DEC unchanged. State=DMEM_WAIT.
  - Leave on the dmem_ready=1 cycle, then re-evaluate normally that same cycle.
- 2) Taken branch (valid_DEC & branch_taken, not frozen):
  - PC_IF<=branch_target; valid_DEC<=0; flush_DEC=1; hold_IF=0.
  - flush_cnt++. Load counter with BRANCH_PENALTY-1.
  - Go to REDIRECT if the counter is nonzero, else RUN.
  - The branch overrides a simultaneous load-use or imem wait.
- 3) REDIRECT:
  - Each cycle flush_DEC=1, valid_DEC<=0, PC_IF advances by +4 only if imem_ready.
  - Decrement counter; go to RUN when it reaches 0.
  - branch_taken is ignored, because valid_DEC=0.
- 4) Load-use hazard: valid_DEC & is_load_DEC & rd_DEC!=0 & ((uses_rs1_IF & rs1_IF==rd_DEC) | (uses_rs2_IF & rs2_IF==rd_DEC)).
  - hold_IF=1, flush_DEC=1, PC_IF unchanged, valid_DEC<=0.
  - Exactly one bubble: LOAD_STALL for one cycle, then RUN. A second hazard is impossible because DEC now holds a bubble.
- 5) imem_ready=0:
  - hold_IF=1, flush_DEC=1, PC_IF unchanged, valid_DEC<=0. Stay in RUN.
- 6) Normal advance:
  - PC_DEC<=PC_IF; PC_IF<=PC_IF+4 (mod 2^32, wraps FFFF_FFFC->0000_0000); valid_DEC<=1.
- Output and counter rules:
  - hold_DEC=1 only in the freeze case.
  - PC_DEC is not updated when a bubble is loaded.
  - stall_cnt increments on every cycle with hold_IF=1.
  - Both counters saturate at all-ones.
- No X on outputs after reset, regardless of input X.

Decomposition:
- Shared package pipe_pkg:
  - state enum seq_state_t {RUN, REDIRECT, LOAD_STALL, DMEM_WAIT};
  - constant PC_STEP=32'd4;
  - constant X0=5'd0.
- One sub-module: hazard_detect, the combinational load-use compare producing load_use.
- FSM, PC registers and counters stay in pipeline_sequencer.

Test Plan:
- Reset: nReset low mid-stream at PC_IF=0x40 -> PC_IF=0, valid_DEC=0, counters 0 immediately, before any clock edge.
- Straight-line: imem_ready=1 for 4 cycles -> PC_IF 0,4,8,C,10; valid_DEC=1 from cycle 2; PC_DEC lags PC_IF by 4.
- Taken branch, BRANCH_PENALTY=2: at PC_DEC=0x8, branch_taken=1, target=0x100.
  - -> next PC_IF=0x100; flush_DEC=1 for 2 cycles; flush_cnt=1.
  - -> valid_DEC=1 with PC_DEC=0x100 after the bubbles.
- Load-use: is_load_DEC=1, rd_DEC=5, rs2_IF=5, uses_rs2_IF=1.
  - -> one cycle hold_IF=1, PC_IF held, one bubble, stall_cnt=1.
  - -> same stimulus with rd_DEC=0 produces no stall.
- Priority: dmem_ready=0 with mem_op_DEC=1 and simultaneous branch_taken=1.
  - -> freeze for 3 cycles, PC_IF unchanged.
  - -> redirect occurs in the cycle dmem_ready=1.
- Wrap and saturation:
  - PC_IF=0xFFFF_FFFC advancing -> 0x0000_0000.
  - With CNT_W=4, 20 stall cycles -> stall_cnt=0xF.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the fetch/decode front-end sequencer.
//   seq_state_t : sequencer FSM state
//   PC_STEP     : fetch PC increment for one 32-bit instruction
//   X0          : architectural zero register index (never a real producer)
package pipe_pkg;

   typedef enum logic [1:0] {
      RUN,
      REDIRECT,
      LOAD_STALL,
      DMEM_WAIT
   } seq_state_t;

   localparam logic [31:0] PC_STEP = 32'd4;
   localparam logic [4:0]  X0      = 5'd0;

   // Sequential fetch address; wraps modulo 2^32.
   function automatic logic [31:0] next_pc(input logic [31:0] pc);
      return pc + PC_STEP;
   endfunction

endpackage

// File: rtl/pipeline_sequencer_if.sv
// Bundle of all non-clock/reset signals between the front-end sequencer and
// the surrounding pipeline (memories, register-file decode, branching unit).
//   master : the sequencer (owns PCs, valid, hold/flush and counters)
//   slave  : the pipeline side driving memory handshakes and decode fields
interface pipeline_sequencer_if #(
   parameter int unsigned CNT_W = 16
);
   logic              imem_ready;
   logic              dmem_ready;
   logic              mem_op_DEC;
   logic              is_load_DEC;
   logic [4:0]        rd_DEC;
   logic [4:0]        rs1_IF;
   logic [4:0]        rs2_IF;
   logic              uses_rs1_IF;
   logic              uses_rs2_IF;
   logic              branch_taken;
   logic [31:0]       branch_target;
   logic [31:0]       PC_IF;
   logic [31:0]       PC_DEC;
   logic              valid_DEC;
   logic              hold_IF;
   logic              hold_DEC;
   logic              flush_DEC;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;

   modport master (
      input  imem_ready, dmem_ready, mem_op_DEC, is_load_DEC, rd_DEC,
             rs1_IF, rs2_IF, uses_rs1_IF, uses_rs2_IF, branch_taken, branch_target,
      output PC_IF, PC_DEC, valid_DEC, hold_IF, hold_DEC, flush_DEC, stall_cnt, flush_cnt
   );

   modport slave (
      output imem_ready, dmem_ready, mem_op_DEC, is_load_DEC, rd_DEC,
             rs1_IF, rs2_IF, uses_rs1_IF, uses_rs2_IF, branch_taken, branch_target,
      input  PC_IF, PC_DEC, valid_DEC, hold_IF, hold_DEC, flush_DEC, stall_cnt, flush_cnt
   );

endinterface

// File: rtl/pipeline_sequencer_hazard_detect.sv
// hazard_detect: combinational load-use check between the load in DEC and
// the source operands of the instruction currently in IF.
//   valid_i                : DEC holds a real instruction
//   is_load_i, rd_i        : DEC is a load and its destination
//   rs1_i/rs2_i, uses_*_i  : IF source registers and whether they are read
//   load_use_o             : IF must wait one cycle for the load result
module hazard_detect
   import pipe_pkg::*;
(
   input  logic       valid_i,
   input  logic       is_load_i,
   input  logic [4:0] rd_i,
   input  logic [4:0] rs1_i,
   input  logic [4:0] rs2_i,
   input  logic       uses_rs1_i,
   input  logic       uses_rs2_i,
   output logic       load_use_o
);

   logic rs1_hit;
   logic rs2_hit;

   always_comb begin
      rs1_hit    = uses_rs1_i && (rs1_i == rd_i);
      rs2_hit    = uses_rs2_i && (rs2_i == rd_i);
      // x0 is never written, so a load targeting it cannot create a dependency.
      load_use_o = valid_i && is_load_i && (rd_i != X0) && (rs1_hit || rs2_hit);
   end

endmodule

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: front-end controller of the 2-stage fetch/decode pipe.
// Owns PC_IF, PC_DEC and valid_DEC, sequences branch redirects, load-use
// bubbles, instruction-memory waits and data-memory freezes, and drives the
// hold/flush controls of the IF/DEC pipeline registers.
//   Clock  : system clock, rising edge
//   nReset : asynchronous active-low reset
//   bus    : handshake/decode inputs in, PCs/valid/hold/flush/counters out
// Per-cycle priority: dmem freeze > taken branch > redirect bubbles >
// load-use bubble > imem wait > normal advance.
module pipeline_sequencer
   import pipe_pkg::*;
#(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int unsigned BRANCH_PENALTY = 1,
   parameter int unsigned CNT_W          = 16
) (
   input  logic                 Clock,
   input  logic                 nReset,
   pipeline_sequencer_if.master bus
);

   // Remaining redirect bubbles after the branch cycle itself (0..2).
   localparam logic [1:0] PENALTY_INIT = 2'(BRANCH_PENALTY - 1);

   seq_state_t       state_q,     state_d;
   logic [31:0]      pc_if_q,     pc_if_d;
   logic [31:0]      pc_dec_q,    pc_dec_d;
   logic             valid_dec_q, valid_dec_d;
   logic [1:0]       pen_cnt_q,   pen_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic dmem_wait;
   logic load_use;
   logic hold_if;
   logic hold_dec;
   logic flush_dec;
   logic redirect_taken;

   hazard_detect u_hazard_detect (
      .valid_i    (valid_dec_q),
      .is_load_i  (bus.is_load_DEC),
      .rd_i       (bus.rd_DEC),
      .rs1_i      (bus.rs1_IF),
      .rs2_i      (bus.rs2_IF),
      .uses_rs1_i (bus.uses_rs1_IF),
      .uses_rs2_i (bus.uses_rs2_IF),
      .load_use_o (load_use)
   );

   assign dmem_wait = valid_dec_q && bus.mem_op_DEC && !bus.dmem_ready;

   // Next-state and pipeline-control decode.
   always_comb begin
      state_d        = state_q;
      pc_if_d        = pc_if_q;
      pc_dec_d       = pc_dec_q;
      valid_dec_d    = valid_dec_q;
      pen_cnt_d      = pen_cnt_q;
      hold_if        = 1'b0;
      hold_dec       = 1'b0;
      flush_dec      = 1'b0;
      redirect_taken = 1'b0;

      if (dmem_wait) begin
         // Freeze: nothing moves until the data access completes.
         hold_if  = 1'b1;
         hold_dec = 1'b1;
         state_d  = DMEM_WAIT;
      end else if (valid_dec_q && bus.branch_taken) begin
         pc_if_d        = bus.branch_target;
         valid_dec_d    = 1'b0;
         flush_dec      = 1'b1;
         redirect_taken = 1'b1;
         pen_cnt_d      = PENALTY_INIT;
         state_d        = (PENALTY_INIT != 2'd0) ? REDIRECT : RUN;
      end else if (state_q == REDIRECT) begin
         flush_dec   = 1'b1;
         valid_dec_d = 1'b0;
         if (bus.imem_ready) begin
            pc_if_d = next_pc(pc_if_q);
         end
         pen_cnt_d = pen_cnt_q - 2'd1;
         state_d   = (pen_cnt_q == 2'd1) ? RUN : REDIRECT;
      end else if (load_use) begin
         hold_if     = 1'b1;
         flush_dec   = 1'b1;
         valid_dec_d = 1'b0;
         state_d     = LOAD_STALL;
      end else if (!bus.imem_ready) begin
         hold_if     = 1'b1;
         flush_dec   = 1'b1;
         valid_dec_d = 1'b0;
         state_d     = RUN;
      end else begin
         pc_dec_d    = pc_if_q;
         pc_if_d     = next_pc(pc_if_q);
         valid_dec_d = 1'b1;
         state_d     = RUN;
      end
   end

   // Saturating bring-up statistics.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (hold_if && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (redirect_taken && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state_q     <= RUN;
         pc_if_q     <= RESET_PC;
         pc_dec_q    <= 32'h0000_0000;
         valid_dec_q <= 1'b0;
         pen_cnt_q   <= 2'd0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         pc_if_q     <= pc_if_d;
         pc_dec_q    <= pc_dec_d;
         valid_dec_q <= valid_dec_d;
         pen_cnt_q   <= pen_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign bus.PC_IF     = pc_if_q;
   assign bus.PC_DEC    = pc_dec_q;
   assign bus.valid_DEC = valid_dec_q;
   assign bus.hold_IF   = hold_if;
   assign bus.hold_DEC  = hold_dec;
   assign bus.flush_DEC = flush_dec;
   assign bus.stall_cnt = stall_cnt_q;
   assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: directed scenarios followed by
// randomized traffic compared against a behavioural model of the pipe.
module tb_pipeline_sequencer;

   localparam int unsigned CNT_W   = 4;
   localparam int unsigned PENALTY = 2;
   localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   checks = 0;
   int   errors = 0;

   pipeline_sequencer_if #(.CNT_W(CNT_W)) bus ();

   pipeline_sequencer #(
      .RESET_PC       (32'h0000_0000),
      .BRANCH_PENALTY (PENALTY),
      .CNT_W          (CNT_W)
   ) dut (
      .Clock  (clk),
      .nReset (rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic set_idle();
      bus.imem_ready    = 1'b1;
      bus.dmem_ready    = 1'b1;
      bus.mem_op_DEC    = 1'b0;
      bus.is_load_DEC   = 1'b0;
      bus.rd_DEC        = 5'd0;
      bus.rs1_IF        = 5'd0;
      bus.rs2_IF        = 5'd0;
      bus.uses_rs1_IF   = 1'b0;
      bus.uses_rs2_IF   = 1'b0;
      bus.branch_taken  = 1'b0;
      bus.branch_target = 32'h0;
   endtask

   task automatic advance(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Leaves the bench 1 time unit after a clock edge with the DUT fresh out of reset.
   task automatic do_reset();
      set_idle();
      rst_n = 1'b0;
      #1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      set_idle();
      #1 rst_n = 1'b0;
      #1;
      checks++; if (bus.PC_IF !== 32'h0 || bus.PC_DEC !== 32'h0 || bus.valid_DEC !== 1'b0) begin
         errors++;
         $display("FAIL reset_init: pc_if=%h pc_dec=%h valid=%b want 0/0/0",
                  bus.PC_IF, bus.PC_DEC, bus.valid_DEC);
      end
      checks++; if (bus.stall_cnt !== 4'h0 || bus.flush_cnt !== 4'h0) begin
         errors++;
         $display("FAIL reset_init_cnt: stall=%h flush=%h want 0/0", bus.stall_cnt, bus.flush_cnt);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.imem_ready = 1'b0;
      advance(2);
      bus.imem_ready = 1'b1;
      advance(16);
      checks++; if (bus.PC_IF !== 32'h40 || bus.stall_cnt !== 4'd2) begin
         errors++;
         $display("FAIL reset_pre: pc_if=%h stall=%0d want 40/2", bus.PC_IF, bus.stall_cnt);
      end
      rst_n = 1'b0;
      #1;
      checks++; if (bus.PC_IF !== 32'h0 || bus.valid_DEC !== 1'b0 || bus.stall_cnt !== 4'h0
                    || bus.flush_cnt !== 4'h0) begin
         errors++;
         $display("FAIL reset_async: pc_if=%h valid=%b stall=%h flush=%h want 0/0/0/0",
                  bus.PC_IF, bus.valid_DEC, bus.stall_cnt, bus.flush_cnt);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_straight_line();
      do_reset();
      checks++; if (bus.PC_IF !== 32'h0 || bus.valid_DEC !== 1'b0) begin
         errors++;
         $display("FAIL straight_start: pc_if=%h valid=%b want 0/0", bus.PC_IF, bus.valid_DEC);
      end
      for (int i = 1; i <= 4; i++) begin
         advance(1);
         checks++; if (bus.PC_IF !== 32'(4 * i) || bus.PC_DEC !== 32'(4 * (i - 1))
                       || bus.valid_DEC !== 1'b1 || bus.hold_IF !== 1'b0 || bus.flush_DEC !== 1'b0) begin
            errors++;
            $display("FAIL straight_%0d: pc_if=%h pc_dec=%h valid=%b hold=%b flush=%b want %h/%h/1/0/0",
                     i, bus.PC_IF, bus.PC_DEC, bus.valid_DEC, bus.hold_IF, bus.flush_DEC,
                     32'(4 * i), 32'(4 * (i - 1)));
         end
      end
   endtask

   task automatic test_branch();
      do_reset();
      advance(3);
      checks++; if (bus.PC_DEC !== 32'h8 || bus.valid_DEC !== 1'b1) begin
         errors++;
         $display("FAIL branch_pre: pc_dec=%h valid=%b want 8/1", bus.PC_DEC, bus.valid_DEC);
      end
      bus.branch_taken  = 1'b1;
      bus.branch_target = 32'h100;
      #1;
      checks++; if (bus.flush_DEC !== 1'b1 || bus.hold_IF !== 1'b0) begin
         errors++;
         $display("FAIL branch_flush1: flush=%b hold=%b want 1/0", bus.flush_DEC, bus.hold_IF);
      end
      advance(1);
      bus.branch_taken = 1'b0;
      bus.imem_ready   = 1'b0;
      #1;
      checks++; if (bus.PC_IF !== 32'h100 || bus.valid_DEC !== 1'b0 || bus.flush_cnt !== 4'd1
                    || bus.flush_DEC !== 1'b1 || bus.hold_IF !== 1'b0) begin
         errors++;
         $display("FAIL branch_flush2: pc_if=%h valid=%b fcnt=%0d flush=%b hold=%b want 100/0/1/1/0",
                  bus.PC_IF, bus.valid_DEC, bus.flush_cnt, bus.flush_DEC, bus.hold_IF);
      end
      advance(1);
      bus.imem_ready = 1'b1;
      #1;
      checks++; if (bus.flush_DEC !== 1'b0 || bus.PC_IF !== 32'h100) begin
         errors++;
         $display("FAIL branch_resume: flush=%b pc_if=%h want 0/100", bus.flush_DEC, bus.PC_IF);
      end
      advance(1);
      checks++; if (bus.valid_DEC !== 1'b1 || bus.PC_DEC !== 32'h100 || bus.PC_IF !== 32'h104
                    || bus.flush_cnt !== 4'd1) begin
         errors++;
         $display("FAIL branch_target: valid=%b pc_dec=%h pc_if=%h fcnt=%0d want 1/100/104/1",
                  bus.valid_DEC, bus.PC_DEC, bus.PC_IF, bus.flush_cnt);
      end
   endtask

   task automatic test_load_use();
      do_reset();
      advance(2);
      bus.is_load_DEC = 1'b1;
      bus.rd_DEC      = 5'd5;
      bus.rs2_IF      = 5'd5;
      bus.uses_rs2_IF = 1'b1;
      #1;
      checks++; if (bus.hold_IF !== 1'b1 || bus.flush_DEC !== 1'b1 || bus.hold_DEC !== 1'b0) begin
         errors++;
         $display("FAIL loaduse_ctrl: hold_if=%b flush=%b hold_dec=%b want 1/1/0",
                  bus.hold_IF, bus.flush_DEC, bus.hold_DEC);
      end
      advance(1);
      checks++; if (bus.PC_IF !== 32'h8 || bus.PC_DEC !== 32'h4 || bus.valid_DEC !== 1'b0
                    || bus.stall_cnt !== 4'd1) begin
         errors++;
         $display("FAIL loaduse_bubble: pc_if=%h pc_dec=%h valid=%b stall=%0d want 8/4/0/1",
                  bus.PC_IF, bus.PC_DEC, bus.valid_DEC, bus.stall_cnt);
      end
      checks++; if (bus.hold_IF !== 1'b0 || bus.flush_DEC !== 1'b0) begin
         errors++;
         $display("FAIL loaduse_once: hold=%b flush=%b want 0/0", bus.hold_IF, bus.flush_DEC);
      end
      advance(1);
      checks++; if (bus.valid_DEC !== 1'b1 || bus.PC_DEC !== 32'h8 || bus.PC_IF !== 32'hC) begin
         errors++;
         $display("FAIL loaduse_resume: valid=%b pc_dec=%h pc_if=%h want 1/8/c",
                  bus.valid_DEC, bus.PC_DEC, bus.PC_IF);
      end
      bus.rd_DEC = 5'd0;
      bus.rs2_IF = 5'd0;
      #1;
      checks++; if (bus.hold_IF !== 1'b0 || bus.flush_DEC !== 1'b0) begin
         errors++;
         $display("FAIL loaduse_x0: hold=%b flush=%b want 0/0", bus.hold_IF, bus.flush_DEC);
      end
      advance(1);
      checks++; if (bus.PC_IF !== 32'h10 || bus.stall_cnt !== 4'd1) begin
         errors++;
         $display("FAIL loaduse_x0_adv: pc_if=%h stall=%0d want 10/1", bus.PC_IF, bus.stall_cnt);
      end
   endtask

   task automatic test_priority();
      do_reset();
      advance(2);
      bus.mem_op_DEC    = 1'b1;
      bus.dmem_ready    = 1'b0;
      bus.branch_taken  = 1'b1;
      bus.branch_target = 32'h200;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (bus.hold_IF !== 1'b1 || bus.hold_DEC !== 1'b1 || bus.flush_DEC !== 1'b0) begin
            errors++;
            $display("FAIL freeze_ctrl_%0d: hold_if=%b hold_dec=%b flush=%b want 1/1/0",
                     i, bus.hold_IF, bus.hold_DEC, bus.flush_DEC);
         end
         advance(1);
         checks++; if (bus.PC_IF !== 32'h8 || bus.PC_DEC !== 32'h4 || bus.valid_DEC !== 1'b1) begin
            errors++;
            $display("FAIL freeze_hold_%0d: pc_if=%h pc_dec=%h valid=%b want 8/4/1",
                     i, bus.PC_IF, bus.PC_DEC, bus.valid_DEC);
         end
      end
      bus.dmem_ready = 1'b1;
      #1;
      checks++; if (bus.hold_IF !== 1'b0 || bus.hold_DEC !== 1'b0 || bus.flush_DEC !== 1'b1) begin
         errors++;
         $display("FAIL freeze_release: hold_if=%b hold_dec=%b flush=%b want 0/0/1",
                  bus.hold_IF, bus.hold_DEC, bus.flush_DEC);
      end
      advance(1);
      checks++; if (bus.PC_IF !== 32'h200 || bus.valid_DEC !== 1'b0 || bus.flush_cnt !== 4'd1
                    || bus.stall_cnt !== 4'd3) begin
         errors++;
         $display("FAIL freeze_redirect: pc_if=%h valid=%b fcnt=%0d stall=%0d want 200/0/1/3",
                  bus.PC_IF, bus.valid_DEC, bus.flush_cnt, bus.stall_cnt);
      end
      set_idle();
   endtask

   task automatic test_wrap();
      do_reset();
      advance(1);
      bus.branch_taken  = 1'b1;
      bus.branch_target = 32'hFFFF_FFFC;
      advance(1);
      bus.branch_taken = 1'b0;
      bus.imem_ready   = 1'b0;
      advance(1);
      bus.imem_ready = 1'b1;
      #1;
      checks++; if (bus.PC_IF !== 32'hFFFF_FFFC) begin
         errors++;
         $display("FAIL wrap_pre: pc_if=%h want fffffffc", bus.PC_IF);
      end
      advance(1);
      checks++; if (bus.PC_IF !== 32'h0 || bus.PC_DEC !== 32'hFFFF_FFFC || bus.valid_DEC !== 1'b1) begin
         errors++;
         $display("FAIL wrap: pc_if=%h pc_dec=%h valid=%b want 0/fffffffc/1",
                  bus.PC_IF, bus.PC_DEC, bus.valid_DEC);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      bus.imem_ready = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         advance(1);
         if (i == 14 || i == 15 || i == 20) begin
            checks++; if (bus.stall_cnt !== 4'(i > 15 ? 15 : i)) begin
               errors++;
               $display("FAIL stall_sat_%0d: stall=%0d want %0d", i, bus.stall_cnt, (i > 15 ? 15 : i));
            end
         end
      end
      set_idle();
   endtask

   // Randomized traffic against a behavioural model of the pipe.
   task automatic test_random();
      logic [31:0] m_pc_if, m_pc_dec;
      logic        m_valid;
      int          m_bubbles, m_stall, m_flush;
      logic        e_hold_if, e_hold_dec, e_flush;
      logic        hazard;
      do_reset();
      m_pc_if = 32'h0; m_pc_dec = 32'h0; m_valid = 1'b0;
      m_bubbles = 0; m_stall = 0; m_flush = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         bus.imem_ready    = ($urandom_range(0, 3) != 0);
         bus.dmem_ready    = ($urandom_range(0, 9) < 7);
         bus.mem_op_DEC    = 1'($urandom());
         bus.is_load_DEC   = 1'($urandom());
         bus.rd_DEC        = 5'($urandom_range(0, 7));
         bus.rs1_IF        = 5'($urandom_range(0, 7));
         bus.rs2_IF        = 5'($urandom_range(0, 7));
         bus.uses_rs1_IF   = 1'($urandom());
         bus.uses_rs2_IF   = 1'($urandom());
         bus.branch_taken  = ($urandom_range(0, 4) == 0);
         bus.branch_target = $urandom() & 32'hFFFF_FFFC;
         #1;
         hazard = m_valid && bus.is_load_DEC && bus.rd_DEC != 5'd0
                  && ((bus.uses_rs1_IF && bus.rs1_IF == bus.rd_DEC)
                      || (bus.uses_rs2_IF && bus.rs2_IF == bus.rd_DEC));
         e_hold_if = 1'b0; e_hold_dec = 1'b0; e_flush = 1'b0;
         if (m_valid && bus.mem_op_DEC && !bus.dmem_ready) begin
            e_hold_if = 1'b1; e_hold_dec = 1'b1;
         end else if (m_valid && bus.branch_taken) begin
            e_flush = 1'b1; m_pc_if = bus.branch_target; m_valid = 1'b0;
            m_bubbles = PENALTY - 1;
            if (m_flush < CNT_MAX) m_flush++;
         end else if (m_bubbles > 0) begin
            e_flush = 1'b1; m_valid = 1'b0; m_bubbles--;
            if (bus.imem_ready) m_pc_if = m_pc_if + 32'd4;
         end else if (hazard || !bus.imem_ready) begin
            e_hold_if = 1'b1; e_flush = 1'b1; m_valid = 1'b0;
         end else begin
            m_pc_dec = m_pc_if; m_pc_if = m_pc_if + 32'd4; m_valid = 1'b1;
         end
         if (e_hold_if && m_stall < CNT_MAX) m_stall++;
         checks++; if (bus.hold_IF !== e_hold_if || bus.hold_DEC !== e_hold_dec
                       || bus.flush_DEC !== e_flush) begin
            errors++;
            $display("FAIL rand_ctrl_%0d: hold_if=%b hold_dec=%b flush=%b want %b/%b/%b",
                     cyc, bus.hold_IF, bus.hold_DEC, bus.flush_DEC, e_hold_if, e_hold_dec, e_flush);
         end
         advance(1);
         checks++; if (bus.PC_IF !== m_pc_if || bus.PC_DEC !== m_pc_dec || bus.valid_DEC !== m_valid
                       || bus.stall_cnt !== 4'(m_stall) || bus.flush_cnt !== 4'(m_flush)) begin
            errors++;
            $display("FAIL rand_state_%0d: pc_if=%h pc_dec=%h valid=%b stall=%0d flush=%0d want %h/%h/%b/%0d/%0d",
                     cyc, bus.PC_IF, bus.PC_DEC, bus.valid_DEC, bus.stall_cnt, bus.flush_cnt,
                     m_pc_if, m_pc_dec, m_valid, m_stall, m_flush);
         end
      end
      set_idle();
   endtask

   initial begin
      test_reset();
      test_straight_line();
      test_branch();
      test_load_use();
      test_priority();
      test_wrap();
      test_saturation();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
